pipe_dmem_responder: RTL and testbench
======================================

Name: pipe_dmem_responder

Overview:
- Memory-side responder for the pipeline's MEM-stage data accesses: word address, write enable and store data in; load data and completion out.
- Accepts one load/store request at a time over a valid/ready handshake.
- Inserts a programmable number of wait states, then returns a response over a second valid/ready handshake.
- Gives the pipeline a realistic, stallable data-memory target instead of a zero-latency array.

Parameters:
- AW, 8: word-address width; storage depth is 2^AW 32-bit words.
- WAIT_CYCLES, 2: wait states between request accept and the memory access (0..15).

Ports:
- clk  input  1  rising-edge clock.
- clrn  input  1  asynchronous reset, active-high (1 = reset asserted).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address (the ALU result).
- req_wdata  input  32  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester takes the response.
- rsp_rdata  output  32  load data; for a store, the data written.
- rsp_err  output  1  misaligned-access flag; tied 0 unless DMEM_ALIGN_CHECK_EN is defined.
- busy_cnt  output  16  saturating count of cycles spent outside IDLE.

Behaviour:
- States: IDLE, WAIT, ACCESS, RESP. Encoding lives in the package.
- Reset (clrn=1, asynchronous):
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; busy_cnt=0.
  - Latched request fields cleared. Memory contents are not reset.
- IDLE: req_ready=1.
  - Request accepted on a clk edge with req_valid && req_ready. we, addr and wdata are latched.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise ACCESS.
- WAIT: req_ready=0. Down-counter loaded with WAIT_CYCLES-1 on accept; go to ACCESS when the counter reaches 0.
- ACCESS (exactly 1 cycle): req_ready=0.
  - Word index = addr[AW+1:2]. Bits above AW+1 are ignored, so addresses wrap modulo 2^AW words.
  - Store: mem[index] <= wdata; rsp_rdata <= wdata.
  - Load: rsp_rdata <= mem[index] (synchronous read).
  - Next state RESP.
- RESP: rsp_valid=1 and rsp_rdata held stable until rsp_ready=1.
  - On that edge rsp_valid drops to 0 and the state returns to IDLE.
- Latency and throughput:
  - Accept edge to rsp_valid high = WAIT_CYCLES+2 edges (4 at default).
  - No overlap: req_ready stays 0 from the accept edge until the edge after the response handshake, so back-to-back throughput is one request per WAIT_CYCLES+3 cycles when rsp_ready is held high.
- req_valid while req_ready=0 is ignored; the requester must hold it.
- rsp_ready while rsp_valid=0 is ignored.
- Reset mid-operation:
  - A store aborted in IDLE or WAIT never writes memory.
  - A store whose ACCESS edge has already occurred has written memory.
- busy_cnt: increments on every clk edge where state != IDLE; saturates at 16'hFFFF.
- rsp_rdata is undefined-free: it always holds the last access result, or 0 after reset.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined:
  - A request with addr[1:0] != 0 is accepted normally, but in ACCESS memory is not written.
  - rsp_rdata <= 32'h0000_0000 and rsp_err is 1 for that response. rsp_err is 0 for aligned accesses.
  - rsp_err has the same reset and hold rules as rsp_rdata.
- Not defined: addr[1:0] is ignored (accesses are word-truncated) and rsp_err is constant 0.

Decomposition:
- Package pipe_dmem_pkg holds:
  - State enum/localparams (IDLE=0, WAIT=1, ACCESS=2, RESP=3).
  - Default AW, data width 32.
  - Saturation constant 16'hFFFF.
- One sub-module, pipe_dmem_array: single-port synchronous RAM (clk, we, index[AW-1:0], wdata, rdata) with no reset.
- The FSM, wait counter, handshake and busy counter stay in pipe_dmem_responder.

Test Plan:
- Reset then store: store addr=0x10, wdata=0xDEADBEEF, rsp_ready=1. Expect req_ready low next cycle, rsp_valid high 4 edges after accept, rsp_rdata=0xDEADBEEF. A following load of 0x10 returns 0xDEADBEEF.
- Wrap-around (AW=8): store 0x12345678 to addr=0x404, then load addr=0x004. Expect 0x12345678.
- Response backpressure: load with rsp_ready=0 for 5 cycles. Expect rsp_valid and rsp_rdata stable, req_ready=0 and a held req_valid not accepted. Raise rsp_ready: rsp_valid falls, and the new request is accepted one edge later.
- WAIT_CYCLES=0: expect rsp_valid 2 edges after accept, with busy_cnt incremented by 2 per transaction when rsp_ready=1.
- Reset mid-op: store 0xAAAA5555 to 0x20 (previously 0x0), assert clrn during WAIT. Expect outputs at reset values and a subsequent load of 0x20 returning 0x00000000.
- With DMEM_ALIGN_CHECK_EN: store to addr=0x22. Expect rsp_err=1, rsp_rdata=0, memory unchanged. An aligned load then gives rsp_err=0.

Source files
------------

// File: rtl/pipe_dmem_pkg.sv
// Shared types and constants for the pipelined data-memory responder.
package pipe_dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam int          DEF_AW   = 8;
  localparam int          DATA_W   = 32;
  localparam logic [15:0] BUSY_SAT = 16'hFFFF;

endpackage

// File: rtl/pipe_dmem_array.sv
// Single-port synchronous RAM, 2^AW words, registered read data, no reset.
module pipe_dmem_array
  import pipe_dmem_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] index,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
    end
    rdata <= mem[index];
  end

endmodule

// File: rtl/pipe_dmem_responder.sv
// Stallable data-memory target: accept, WAIT_CYCLES wait states, 1-cycle access, response held until taken.
// One request in flight; response WAIT_CYCLES+2 edges after accept; DMEM_ALIGN_CHECK_EN flags misaligned accesses.
module pipe_dmem_responder
  import pipe_dmem_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       busy_cnt
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        wait_cnt;
  logic              we_q;
  logic [AW-1:0]     index_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  logic              misaligned;
  logic              access_we;
  logic [AW-1:0]     ram_index;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_addr_bits;

  assign req_ready        = (state == S_IDLE);
  assign rsp_valid        = (state == S_RESP);
  assign accept           = req_ready && req_valid;
  assign unused_addr_bits = ^{req_addr[DATA_W-1:AW+2], req_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0] off_q;
  assign misaligned = (off_q != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // The RAM read is launched at the accept edge (and repeated through WAIT) so the
  // registered read data is already valid when ACCESS samples it.
  assign ram_index = (state == S_IDLE) ? req_addr[AW+1:2] : index_q;
  assign access_we = (state == S_ACCESS) && we_q && !misaligned;

  pipe_dmem_array #(
    .AW (AW),
    .DW (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (access_we),
    .index (ram_index),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid) state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (wait_cnt == 4'd0) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      wait_cnt  <= 4'd0;
      we_q      <= 1'b0;
      index_q   <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy_cnt  <= 16'd0;
`ifdef DMEM_ALIGN_CHECK_EN
      off_q     <= 2'b00;
`endif
    end else begin
      if (accept) begin
        we_q     <= req_we;
        index_q  <= req_addr[AW+1:2];
        wdata_q  <= req_wdata;
        wait_cnt <= WAIT_LOAD;
`ifdef DMEM_ALIGN_CHECK_EN
        off_q    <= req_addr[1:0];
`endif
      end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      if (state == S_ACCESS) begin
        if (misaligned) begin
          rsp_rdata <= '0;
        end else if (we_q) begin
          rsp_rdata <= wdata_q;
        end else begin
          rsp_rdata <= ram_rdata;
        end
        rsp_err <= misaligned;
      end

      if ((state != S_IDLE) && (busy_cnt != BUSY_SAT)) begin
        busy_cnt <= busy_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_dmem_responder.sv
// Directed + randomized checks of pipe_dmem_responder at WAIT_CYCLES=2 and WAIT_CYCLES=0.
module tb_pipe_dmem_responder;

  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        clrn;
  logic        sel;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;

  logic        req_ready_a, rsp_valid_a, rsp_err_a;
  logic [31:0] rsp_rdata_a;
  logic [15:0] busy_a;
  logic        req_ready_b, rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_rdata_b;
  logic [15:0] busy_b;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [15:0] busy_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] mem_m [int];

  always #5 clk = ~clk;

  assign req_ready = sel ? req_ready_b : req_ready_a;
  assign rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
  assign rsp_err   = sel ? rsp_err_b   : rsp_err_a;
  assign rsp_rdata = sel ? rsp_rdata_b : rsp_rdata_a;
  assign busy_cnt  = sel ? busy_b      : busy_a;

  pipe_dmem_responder #(.AW(AW), .WAIT_CYCLES(2)) dut (
    .clk(clk), .clrn(clrn),
    .req_valid(req_valid && !sel), .req_ready(req_ready_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a), .busy_cnt(busy_a)
  );

  pipe_dmem_responder #(.AW(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .clrn(clrn),
    .req_valid(req_valid && sel), .req_ready(req_ready_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .busy_cnt(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: word memory keyed by (instance, word index); misaligned accesses
  // are rejected only when the alignment check is compiled in.
  function automatic void model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                    output logic [31:0] exp_rd, output logic exp_err, output bit known);
    int key;
    bit mis;
    key   = (sel ? 1024 : 0) + int'((addr >> 2) % (1 << AW));
    mis   = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    mis   = (addr % 4) != 0;
`endif
    exp_err = mis;
    known   = 1'b1;
    exp_rd  = 32'h0;
    if (mis) begin
      exp_rd = 32'h0;
    end else if (we) begin
      mem_m[key] = wdata;
      exp_rd     = wdata;
    end else if (mem_m.exists(key)) begin
      exp_rd = mem_m[key];
    end else begin
      known = 1'b0;
    end
  endfunction

  task automatic wait_rsp(output int lat);
    lat = 1;
    while ((rsp_valid !== 1'b1) && (lat < 40)) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    logic [31:0] exp_rd, held;
    logic        exp_err;
    bit          known;
    int          lat, wc;
    logic [15:0] b0;
    wc = sel ? 0 : 2;
    b0 = busy_cnt;
    chk("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("accept_ready_low", 32'(req_ready), 32'd0);
    wait_rsp(lat);
    chk("latency", 32'(lat), 32'(wc + 2));
    model_txn(we, addr, wdata, exp_rd, exp_err, known);
    if (known) chk("rdata", rsp_rdata, exp_rd);
    chk("err", 32'(rsp_err), 32'(exp_err));
    held = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, held);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    chk("back_idle", 32'(req_ready), 32'd1);
    chk("busy_delta", 32'(16'(busy_cnt - b0)), 32'(wc + 2 + hold));
  endtask

  initial begin
    int          lat;
    logic [31:0] a;
    sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; clrn = 1'b0;
    #2 clrn = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy_cnt), 32'd0);
    @(negedge clk) clrn = 1'b0;
    @(posedge clk); #1;

    // Store then load back
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 0);
    chk("store_echo", rsp_rdata, 32'hDEADBEEF);
    run_txn(1'b0, 32'h10, 32'h0, 0);
    chk("load_10", rsp_rdata, 32'hDEADBEEF);

    // Address wrap modulo 2^AW words
    run_txn(1'b1, 32'h404, 32'h12345678, 0);
    run_txn(1'b0, 32'h004, 32'h0, 0);
    chk("wrap_load", rsp_rdata, 32'h12345678);

    // Response backpressure with a held follow-on request
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    chk("bp_latency", 32'(lat), 32'd4);
    req_valid = 1'b1; req_addr = 32'h404;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("bp_ready_back", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_second_accept", 32'(req_ready), 32'd0);
    wait_rsp(lat);
    chk("bp_second_rdata", rsp_rdata, 32'h12345678);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset during WAIT aborts the store
    run_txn(1'b1, 32'h20, 32'h0, 0);
    run_txn(1'b0, 32'h10, 32'h0, 0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA5555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_in_wait", 32'(req_ready), 32'd0);
    clrn = 1'b1;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rdata", rsp_rdata, 32'h0);
    chk("mid_rst_err", 32'(rsp_err), 32'd0);
    chk("mid_rst_busy", 32'(busy_cnt), 32'd0);
    @(negedge clk) clrn = 1'b0;
    @(posedge clk); #1;
    run_txn(1'b0, 32'h20, 32'h0, 1);
    chk("abort_no_write", rsp_rdata, 32'h0);

    // Misaligned store, then aligned load of the same word
    run_txn(1'b1, 32'h22, 32'hCAFEF00D, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis_err", 32'(rsp_err), 32'd1);
    chk("mis_rdata", rsp_rdata, 32'h0);
`endif
    run_txn(1'b0, 32'h20, 32'h0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis_no_write", rsp_rdata, 32'h0);
    chk("aligned_err", 32'(rsp_err), 32'd0);
`else
    chk("trunc_write", rsp_rdata, 32'hCAFEF00D);
`endif

    // Zero wait states
    sel = 1'b1; #1;
    run_txn(1'b1, 32'h30, 32'h0BADCAFE, 0);
    run_txn(1'b0, 32'h30, 32'h0, 2);
    chk("w0_load", rsp_rdata, 32'h0BADCAFE);

    // Randomized traffic on both instances
    for (int n = 0; n < 60; n++) begin
      sel = 1'($urandom_range(0, 1));
      #1;
      a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
      run_txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
